// File: rtl/regfile_port_arbiter.sv
// Shares the register file's write port and read port B between the core pipeline and a
// debug/loader requester. The core has priority; debug is forced through after STARVE_LIMIT cycles.
module regfile_port_arbiter #(
   parameter int unsigned STARVE_LIMIT = 8,
   parameter logic [4:0]  ZERO_REG     = 5'd31
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [4:0]  core_ra,
   input  logic [4:0]  core_rb,
   input  logic [4:0]  core_rc,
   input  logic        core_ra2sel,
   input  logic        core_rd_en,
   input  logic        core_we,
   input  logic [31:0] core_wd,
   output logic        core_stall,
   input  logic        dbg_req,
   input  logic        dbg_we,
   input  logic [4:0]  dbg_addr,
   input  logic [31:0] dbg_wdata,
   output logic        dbg_gnt,
   output logic        dbg_rvalid,
   output logic [31:0] dbg_rdata,
   output logic [4:0]  rf_ra,
   output logic [4:0]  rf_rb,
   output logic [4:0]  rf_rc,
   output logic        rf_werf,
   output logic        rf_ra2sel,
   output logic [31:0] rf_wd,
   input  logic [31:0] rf_rd2
);

   typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

   localparam logic [7:0] LIMIT_M1 = 8'(STARVE_LIMIT - 1);

   state_t      state;
   logic [7:0]  starve_cnt;
   logic        lat_we;
   logic [4:0]  lat_addr;
   logic [31:0] lat_wdata;
   logic        core_busy;
   logic        grant;

   assign core_busy = core_we | core_rd_en;
   assign grant     = dbg_req & (~core_busy | (starve_cnt == LIMIT_M1));

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state      <= IDLE;
         starve_cnt <= '0;
         dbg_gnt    <= 1'b0;
         dbg_rvalid <= 1'b0;
         dbg_rdata  <= '0;
         core_stall <= 1'b0;
         lat_we     <= 1'b0;
         lat_addr   <= '0;
         lat_wdata  <= '0;
      end else begin
         case (state)
            IDLE: begin
               dbg_rvalid <= 1'b0;
               if (grant) begin
                  state      <= ACCESS;
                  lat_we     <= dbg_we;
                  lat_addr   <= dbg_addr;
                  lat_wdata  <= dbg_wdata;
                  starve_cnt <= '0;
                  dbg_gnt    <= 1'b1;
                  core_stall <= 1'b1;
               end else if (dbg_req) begin
                  if (starve_cnt != LIMIT_M1)
                     starve_cnt <= starve_cnt + 8'd1;
               end else begin
                  starve_cnt <= '0;
               end
            end
            ACCESS: begin
               state      <= RESP;
               dbg_gnt    <= 1'b0;
               core_stall <= 1'b0;
               dbg_rvalid <= 1'b1;
               // Zero-register accesses report 0 whether read or write echo.
               if (lat_addr == ZERO_REG)
                  dbg_rdata <= '0;
               else if (lat_we)
                  dbg_rdata <= lat_wdata;
               else
                  dbg_rdata <= rf_rd2;
            end
            RESP: begin
               state      <= IDLE;
               dbg_rvalid <= 1'b0;
            end
            default: begin
               state      <= IDLE;
               dbg_gnt    <= 1'b0;
               core_stall <= 1'b0;
               dbg_rvalid <= 1'b0;
            end
         endcase
      end
   end

   always_comb begin
      rf_ra     = core_ra;
      rf_rb     = core_rb;
      rf_rc     = core_rc;
      rf_ra2sel = core_ra2sel;
      rf_wd     = core_wd;
      rf_werf   = core_we;
      if (state == ACCESS) begin
         rf_rb     = lat_addr;
         rf_rc     = lat_addr;
         rf_ra2sel = 1'b0;
         rf_wd     = lat_wdata;
         rf_werf   = lat_we & (lat_addr != ZERO_REG);
      end
      if (!rst_n)
         rf_werf = 1'b0;
   end

endmodule

// File: tb/tb_regfile_port_arbiter.sv
// Directed bench for regfile_port_arbiter with a behavioural 32x32 register file behind it.
module tb_regfile_port_arbiter;

   logic        clk;
   logic        rst_n;
   logic [4:0]  core_ra, core_rb, core_rc;
   logic        core_ra2sel, core_rd_en, core_we;
   logic [31:0] core_wd;
   logic        core_stall;
   logic        dbg_req, dbg_we;
   logic [4:0]  dbg_addr;
   logic [31:0] dbg_wdata;
   logic        dbg_gnt, dbg_rvalid;
   logic [31:0] dbg_rdata;
   logic [4:0]  rf_ra, rf_rb, rf_rc;
   logic        rf_werf, rf_ra2sel;
   logic [31:0] rf_wd, rf_rd2;

   logic [31:0] mem [32];
   logic [4:0]  rd_addr;
   int          total = 0;
   int          bad   = 0;

   regfile_port_arbiter #(.STARVE_LIMIT(8), .ZERO_REG(5'd31)) dut (
      .clk(clk), .rst_n(rst_n),
      .core_ra(core_ra), .core_rb(core_rb), .core_rc(core_rc),
      .core_ra2sel(core_ra2sel), .core_rd_en(core_rd_en), .core_we(core_we),
      .core_wd(core_wd), .core_stall(core_stall),
      .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
      .dbg_gnt(dbg_gnt), .dbg_rvalid(dbg_rvalid), .dbg_rdata(dbg_rdata),
      .rf_ra(rf_ra), .rf_rb(rf_rb), .rf_rc(rf_rc), .rf_werf(rf_werf),
      .rf_ra2sel(rf_ra2sel), .rf_wd(rf_wd), .rf_rd2(rf_rd2)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always_comb begin
      rd_addr = rf_ra2sel ? rf_rc : rf_rb;
      rf_rd2  = (rd_addr == 5'd31) ? 32'd0 : mem[rd_addr];
   end

   always_ff @(posedge clk)
      if (rf_werf && rf_rc != 5'd31)
         mem[rf_rc] <= rf_wd;

   task automatic chk_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #2;
   endtask

   // Full debug transaction with the core idle: request, grant, response, back to IDLE.
   task automatic dbg_access(input logic we, input logic [4:0] addr, input logic [31:0] wdata,
                             input logic [31:0] exp_rdata, input string tag);
      dbg_req = 1'b1; dbg_we = we; dbg_addr = addr; dbg_wdata = wdata;
      step();
      chk_val({tag, "_gnt"}, 32'(dbg_gnt), 32'd1);
      dbg_req = 1'b0;
      step();
      chk_val({tag, "_rvalid"}, 32'(dbg_rvalid), 32'd1);
      chk_val({tag, "_rdata"}, dbg_rdata, exp_rdata);
      step();
   endtask

   initial begin
      rst_n = 1'b0;
      core_ra = '0; core_rb = '0; core_rc = '0;
      core_ra2sel = 1'b0; core_rd_en = 1'b0; core_we = 1'b0; core_wd = '0;
      dbg_req = 1'b0; dbg_we = 1'b0; dbg_addr = '0; dbg_wdata = '0;
      step();
      step();
      chk_val("rst_gnt", 32'(dbg_gnt), 32'd0);
      chk_val("rst_rvalid", 32'(dbg_rvalid), 32'd0);
      chk_val("rst_stall", 32'(core_stall), 32'd0);
      chk_val("rst_rdata", dbg_rdata, 32'd0);
      chk_val("rst_werf", 32'(rf_werf), 32'd0);
      rst_n = 1'b1;
      step();

      // Idle core, debug write r5 then read it back
      dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 5'd5; dbg_wdata = 32'hDEADBEEF;
      step();
      chk_val("w5_gnt", 32'(dbg_gnt), 32'd1);
      chk_val("w5_stall", 32'(core_stall), 32'd1);
      chk_val("w5_werf", 32'(rf_werf), 32'd1);
      chk_val("w5_rc", 32'(rf_rc), 32'd5);
      chk_val("w5_wd", rf_wd, 32'hDEADBEEF);
      dbg_req = 1'b0;
      step();
      chk_val("w5_rvalid", 32'(dbg_rvalid), 32'd1);
      chk_val("w5_rdata", dbg_rdata, 32'hDEADBEEF);
      chk_val("w5_gnt_off", 32'(dbg_gnt), 32'd0);
      step();
      chk_val("w5_rvalid_off", 32'(dbg_rvalid), 32'd0);
      dbg_access(1'b0, 5'd5, 32'h0, 32'hDEADBEEF, "r5");

      // IDLE passthrough
      core_ra = 5'd1; core_rb = 5'd2; core_rc = 5'd7; core_ra2sel = 1'b1;
      core_we = 1'b1; core_wd = 32'h55;
      #1;
      chk_val("pt_ra", 32'(rf_ra), 32'd1);
      chk_val("pt_rb", 32'(rf_rb), 32'd2);
      chk_val("pt_rc", 32'(rf_rc), 32'd7);
      chk_val("pt_ra2sel", 32'(rf_ra2sel), 32'd1);
      chk_val("pt_werf", 32'(rf_werf), 32'd1);
      chk_val("pt_wd", rf_wd, 32'h55);
      step();
      chk_val("pt_gnt", 32'(dbg_gnt), 32'd0);
      chk_val("pt_stall", 32'(core_stall), 32'd0);
      chk_val("pt_mem7", mem[7], 32'h55);

      // Busy core writing r3; debug write r3 is forced through after 8 cycles
      core_rc = 5'd3; core_wd = 32'h1234; core_ra2sel = 1'b0;
      dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 5'd3; dbg_wdata = 32'hAAAA;
      for (int i = 1; i <= 7; i++) begin
         step();
         chk_val($sformatf("starve_nogrant_%0d", i), 32'(dbg_gnt), 32'd0);
      end
      step();
      chk_val("starve_gnt", 32'(dbg_gnt), 32'd1);
      chk_val("starve_stall", 32'(core_stall), 32'd1);
      chk_val("starve_werf", 32'(rf_werf), 32'd1);
      chk_val("starve_rc", 32'(rf_rc), 32'd3);
      chk_val("starve_wd", rf_wd, 32'hAAAA);
      dbg_req = 1'b0;
      step();
      chk_val("starve_mem_dbg", mem[3], 32'hAAAA);
      chk_val("starve_stall_off", 32'(core_stall), 32'd0);
      chk_val("starve_rvalid", 32'(dbg_rvalid), 32'd1);
      step();
      chk_val("starve_mem_core", mem[3], 32'h1234);
      core_we = 1'b0;
      step();

      // Zero register: write dropped, echo and read return 0
      dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 5'd31; dbg_wdata = 32'hFFFFFFFF;
      step();
      chk_val("z_gnt", 32'(dbg_gnt), 32'd1);
      chk_val("z_werf", 32'(rf_werf), 32'd0);
      dbg_req = 1'b0;
      step();
      chk_val("z_rdata", dbg_rdata, 32'd0);
      step();
      dbg_access(1'b0, 5'd3, 32'h0, 32'h1234, "r3");
      dbg_access(1'b0, 5'd31, 32'h0, 32'h0, "r31");

      // Reset asserted during ACCESS abandons the access
      dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 5'd9; dbg_wdata = 32'h99;
      step();
      chk_val("ra_gnt", 32'(dbg_gnt), 32'd1);
      rst_n = 1'b0; dbg_req = 1'b0;
      #1;
      chk_val("ra_werf_in_rst", 32'(rf_werf), 32'd0);
      step();
      chk_val("ra_gnt_off", 32'(dbg_gnt), 32'd0);
      chk_val("ra_rvalid", 32'(dbg_rvalid), 32'd0);
      chk_val("ra_stall", 32'(core_stall), 32'd0);
      chk_val("ra_rdata", dbg_rdata, 32'd0);
      rst_n = 1'b1;
      step();
      chk_val("ra_no_rvalid", 32'(dbg_rvalid), 32'd0);
      dbg_access(1'b1, 5'd9, 32'h77, 32'h77, "ra_fresh");

      // Back-to-back requests with core idle: one access per 3 cycles
      dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 5'd5;
      for (int c = 1; c <= 9; c++) begin
         step();
         chk_val($sformatf("b2b_gnt_%0d", c), 32'(dbg_gnt), 32'((c % 3) == 1));
         chk_val($sformatf("b2b_rvalid_%0d", c), 32'(dbg_rvalid), 32'((c % 3) == 2));
      end
      dbg_req = 1'b0;
      step();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/regfile_port_arbiter.md
Name: regfile_port_arbiter

Overview:
- Shares the single write port and read port B of the register file between the core pipeline and a debug/loader requester.
- The core has priority. Debug is granted when the core is idle, or is forced through after a starvation limit, in which case the core is stalled.
- Drives the regfile's Ra/Rb/Rc, WERF, RA2SEL and WD inputs, and returns debug read data with a valid strobe.

Parameters:
- STARVE_LIMIT, 8: consecutive pending-but-ungranted debug cycles before a forced grant; legal range 1..255.
- ZERO_REG, 31: hardwired-zero register index. Writes to it are dropped; reads of it return 0.

Ports:
- clk  in  1  system clock; all state updates on the rising edge
- rst_n  in  1  synchronous active-low reset
- core_ra  in  5  core read address A
- core_rb  in  5  core read address B
- core_rc  in  5  core write address / alternate read B address
- core_ra2sel  in  1  core RA2SEL (1: port B reads Rc)
- core_rd_en  in  1  core is using the read ports this cycle
- core_we  in  1  core write enable
- core_wd  in  32  core write data
- core_stall  out  1  core must hold its current request; asserted only in the ACCESS state
- dbg_req  in  1  debug request; held until dbg_gnt
- dbg_we  in  1  1 = write, 0 = read
- dbg_addr  in  5  debug register index
- dbg_wdata  in  32  debug write data
- dbg_gnt  out  1  one-cycle grant pulse
- dbg_rvalid  out  1  one-cycle pulse, dbg_rdata valid
- dbg_rdata  out  32  registered debug response
- rf_ra  out  5  to regfile Ra
- rf_rb  out  5  to regfile Rb
- rf_rc  out  5  to regfile Rc
- rf_werf  out  1  to regfile WERF
- rf_ra2sel  out  1  to regfile RA2SEL
- rf_wd  out  32  to regfile WD
- rf_rd2  in  32  regfile RD2 (combinational read)

Behaviour:
- Reset (rst_n=0 at an edge):
  - state=IDLE, starve_cnt=0.
  - dbg_gnt=0, dbg_rvalid=0, dbg_rdata=0, core_stall=0.
  - rf_werf forced 0 while rst_n=0.
  - Any in-flight debug access is abandoned; no rvalid is produced for it.
- States: IDLE, ACCESS, RESP. The state register is updated every cycle. dbg_gnt=1 only in ACCESS, dbg_rvalid=1 only in RESP, core_stall=1 only in ACCESS.
- IDLE:
  - rf_* pass through core_* combinationally; rf_werf=core_we.
  - Transition to ACCESS when dbg_req=1 and either (core_we=0 and core_rd_en=0) or starve_cnt==STARVE_LIMIT-1.
  - On that transition, latch dbg_we, dbg_addr and dbg_wdata, and clear starve_cnt.
  - Else, if dbg_req=1, starve_cnt++ (saturating). If dbg_req=0, starve_cnt=0.
- ACCESS (exactly 1 cycle):
  - rf_rc=lat_addr, rf_rb=lat_addr, rf_ra2sel=0, rf_wd=lat_wdata, rf_ra=core_ra.
  - rf_werf = lat_we and lat_addr!=ZERO_REG.
  - Core write is suppressed: core_we has no effect; the core holds it under stall.
  - At the cycle end, capture dbg_rdata:
    - read of ZERO_REG -> 0
    - other read -> rf_rd2
    - write -> echo lat_wdata (0 if lat_addr==ZERO_REG)
  - Next state is RESP.
- RESP (1 cycle):
  - Passthrough as in IDLE; dbg_rvalid=1.
  - dbg_req is not evaluated and starve_cnt is held.
  - Next state is IDLE.
- Throughput: at most one debug access per 3 cycles. Grant latency is at least 1 cycle from dbg_req. rdata is available 2 cycles after the request edge.
- A debug write and the core's stalled write to the same register: the debug write lands in ACCESS and the core write lands after stall release, so the core value wins.
- Core read-after-debug-write: a core read in RESP sees the new value.
- starve_cnt is 8 bits wide and saturates at STARVE_LIMIT-1.

Test Plan:
- Idle core, dbg write addr=5 data=0xDEADBEEF:
  - Gnt is asserted 1 cycle after req, with rf_werf=1, rf_rc=5.
  - The next cycle has rvalid=1 and rdata=0xDEADBEEF.
  - A later dbg read of addr 5 returns 0xDEADBEEF.
- Core busy continuously (core_we=1), dbg_req held, STARVE_LIMIT=8:
  - Gnt occurs exactly on the 8th cycle after req.
  - core_stall=1 for that single cycle.
  - The core write of 0x1234 to r3 held across the stall lands on the following cycle.
- dbg write addr=31 data=0xFFFFFFFF:
  - rf_werf=0 during ACCESS.
  - rdata=0.
  - A subsequent read of r31 returns 0.
- Passthrough in IDLE:
  - core_ra=1, core_rb=2, core_rc=7, ra2sel=1, we=1, wd=0x55 appear unchanged on rf_*.
  - dbg_gnt and core_stall remain 0.
- rst_n driven low during the ACCESS cycle:
  - Next cycle state=IDLE with rvalid=0, gnt=0, stall=0 and rdata=0.
  - A fresh req after reset is served normally.
- Back-to-back dbg_req held high with the core idle:
  - Gnt pulses at cycles 1, 4, 7 (one access per 3 cycles).
  - rvalid at cycles 2, 5, 8.
